// File: rtl/int_ctrl.sv
// int_ctrl: three-source interrupt controller with a memory-mapped register
// window at 0x7f20-0x7f2f (PEND, MASK, STAT, EOI) and a single request line
// to the CPU driven by an IDLE -> REQ -> SERVICE state machine.
// Fixed priority: Timer0 (bit 0) > Timer1 (bit 1) > external (bit 2).
//
// Build option: define INT_CTRL_EDGE_EN for edge-triggered capture of
// src_irq. When it is undefined, the controller is level-sensitive and
// pending simply follows the registered sources.
module int_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  input  logic [2:0]  src_irq,
  output logic        int_req,
  output logic [1:0]  int_id,
  input  logic        int_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  mask_q, mask_d;
  logic        int_req_q, int_req_d;
  logic [1:0]  int_id_q, int_id_d;

  logic        wr_hit;
  logic        wr_pend, wr_mask, wr_eoi;
  logic        ack_take;
  logic [2:0]  id_onehot;
  logic [2:0]  enabled;

  // Only byte lane 0 carries register data, and the upper address bits are
  // checked locally so a stray bridge strobe cannot touch the registers.
  assign wr_hit  = we[0] && (addr[31:4] == 28'h00007f2);
  assign wr_pend = wr_hit && (addr[3:2] == 2'd0);
  assign wr_mask = wr_hit && (addr[3:2] == 2'd1);
  assign wr_eoi  = wr_hit && (addr[3:2] == 2'd3);

  // The acknowledge only counts while a request is outstanding.
  assign ack_take  = (state_q == ST_REQ) && int_ack;
  assign id_onehot = 3'b001 << int_id_q;
  assign enabled   = pending_q & mask_q;

  // Mask register next state.
  always_comb begin
    mask_d = mask_q;
    if (wr_mask) begin
      mask_d = wdata[2:0];
    end
  end

`ifdef INT_CTRL_EDGE_EN
  logic [2:0] src_prev_q;
  logic [2:0] rise;
  logic [2:0] w1c_clr;
  logic [2:0] ack_clr;

  assign rise    = src_irq & ~src_prev_q;
  assign w1c_clr = wr_pend ? wdata[2:0] : 3'b000;
  assign ack_clr = ack_take ? id_onehot : 3'b000;

  // Edge capture: a new rising edge wins over a clear of the same bit.
  always_comb begin
    pending_d = (pending_q & ~w1c_clr & ~ack_clr) | rise;
  end

  // Previous-sample register; zero after reset so a source held high across
  // reset release is seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_prev_q <= 3'b000;
    end else begin
      src_prev_q <= src_irq;
    end
  end
`else
  logic unused_level;
  assign unused_level = wr_pend;

  // Level mode: pending mirrors the registered sources; clears cannot stick.
  always_comb begin
    pending_d = src_irq;
  end
`endif

  // Request state machine: next state, latched id and request line.
  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    case (state_q)
      ST_REQ: begin
        if (int_ack) begin
          state_d = ST_SERVICE;
        end else if ((pending_d & mask_d & id_onehot) == 3'b000) begin
          // Source withdrawn (masked or cleared) before it was taken.
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // IDLE, and the unused encoding which behaves like IDLE.
        if (enabled != 3'b000) begin
          state_d = ST_REQ;
          if (enabled[0]) begin
            int_id_d = 2'd0;
          end else if (enabled[1]) begin
            int_id_d = 2'd1;
          end else begin
            int_id_d = 2'd2;
          end
        end
      end
    endcase
    int_req_d = (state_d == ST_REQ);
  end

  // State, register file and registered CPU outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 3'b000;
      mask_q    <= 3'b000;
      int_req_q <= 1'b0;
      int_id_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  // Combinational register read; EOI and unused bits read as zero.
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr[3:2])
      2'd0:    rdata = {29'd0, pending_q};
      2'd1:    rdata = {29'd0, mask_q};
      2'd2:    rdata = {28'd0, int_id_q, state_q};
      default: rdata = 32'h0000_0000;
    endcase
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;

  logic unused_bits;
  assign unused_bits = ^{wdata[31:3], we[3:1], addr[1:0]};

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl. Stimulus pushes expected register reads and
// request-line snapshots into chk_q and expected request ids into req_q; a
// monitor on the falling clock edge pops and compares them, and every rising
// edge of int_req consumes one entry of req_q.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic [2:0]  src_irq;
  logic        int_req;
  logic [1:0]  int_id;
  logic        int_ack;

  localparam logic [31:0] A_PEND = 32'h0000_7f20;
  localparam logic [31:0] A_MASK = 32'h0000_7f24;
  localparam logic [31:0] A_STAT = 32'h0000_7f28;
  localparam logic [31:0] A_EOI  = 32'h0000_7f2c;

`ifdef INT_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct {
    string       name;
    int          kind;   // 0: rdata, 1: {int_req, int_id}
    logic [31:0] exp;
  } item_t;

  item_t chk_q[$];
  int    req_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  logic  req_prev = 1'b0;

  int_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .src_irq (src_irq),
    .int_req (int_req),
    .int_id  (int_id),
    .int_ack (int_ack)
  );

  always #5 clk = ~clk;

  // Monitor: compares queued expectations and request-line rises.
  initial begin
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        automatic item_t it = chk_q.pop_front();
        automatic logic [31:0] act;
        act = (it.kind == 0) ? rdata : {29'd0, int_req, int_id};
        n_chk++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
        end else begin
          $display("ok   %s: 0x%0h", it.name, act);
        end
      end
      if (int_req === 1'b1 && req_prev === 1'b0) begin
        n_chk++;
        if (req_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req: got id %0d expected no request", int_id);
        end else begin
          automatic int e = req_q.pop_front();
          if (int_id !== e[1:0]) begin
            n_fail++;
            $display("FAIL req_id: got %0d expected %0d", int_id, e);
          end else begin
            $display("ok   req_id: %0d", int_id);
          end
        end
      end
      req_prev = int_req;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    chk_q.push_back('{name, 0, exp});
    tick();
  endtask

  task automatic expect_st(input string name, input logic [31:0] exp);
    chk_q.push_back('{name, 1, exp});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr  = a;
    wdata = d;
    we    = be;
    tick();
    we    = 4'h0;
    wdata = 32'h0;
  endtask

  initial begin
    reset   = 1'b1;
    addr    = A_STAT;
    wdata   = 32'h0;
    we      = 4'h0;
    src_irq = 3'b000;
    int_ack = 1'b0;
    repeat (3) tick();

    // Reset state
    expect_st("rst_req", 32'h0);
    expect_rd("rst_stat", A_STAT, 32'h0);
    expect_rd("rst_mask", A_MASK, 32'h0);
    expect_rd("rst_pend", A_PEND, 32'h0);
    reset = 1'b0;
    tick();

    // Timer0 alone, MASK=001: two-cycle latency to int_req
    wr(A_MASK, 32'h1, 4'h1);
    src_irq = 3'b001;
    expect_st("t0_pre", 32'h0);
    tick();
    expect_st("t0_pend_noreq", 32'h0);
    req_q.push_back(0);
    expect_rd("t0_pend", A_PEND, 32'h1);
    expect_st("t0_req", 32'h4);
    expect_rd("t0_stat_req", A_STAT, 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_rd("t0_pend_ack", A_PEND, EDGE ? 32'h0 : 32'h1);
    expect_st("t0_svc_noreq", 32'h0);
    expect_rd("t0_stat_svc", A_STAT, 32'h2);
    src_irq = 3'b000;
    wr(A_EOI, 32'h0, 4'h1);
    expect_rd("t0_stat_eoi", A_STAT, 32'h0);

    // Timer1 and external together, MASK=111: id 1 then id 2
    wr(A_MASK, 32'h7, 4'h1);
    src_irq = 3'b110;
    req_q.push_back(1);
    tick();
    expect_rd("pr_pend", A_PEND, 32'h6);
    expect_rd("pr_stat_req1", A_STAT, 32'h5);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_rd("pr_stat_svc1", A_STAT, 32'h6);
    src_irq = 3'b100;
    req_q.push_back(2);
    wr(A_EOI, 32'h0, 4'h1);
    expect_rd("pr_stat_idle", A_STAT, 32'h4);
    expect_rd("pr_stat_req2", A_STAT, 32'h9);

    // Masking the in-flight source drops the request, PEND untouched
    wr(A_MASK, 32'h0, 4'h1);
    expect_st("mk_noreq", 32'h2);
    expect_rd("mk_stat", A_STAT, 32'h8);
    expect_rd("mk_pend", A_PEND, 32'h4);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_rd("mk_pend_ack_ign", A_PEND, 32'h4);

    // External held high: level mode re-requests after ack + EOI
    wr(A_MASK, 32'h4, 4'h1);
    expect_st("lv_idle", 32'h2);
    req_q.push_back(2);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_st("lv_svc", 32'h2);
    if (!EDGE) req_q.push_back(2);
    wr(A_EOI, 32'h0, 4'h1);
    expect_st("lv_after_eoi", 32'h2);
    tick();
    expect_st("lv_rereq", EDGE ? 32'h2 : 32'h6);
    tick();
    src_irq = 3'b000;
    tick();
    tick();

    // Reset while in SERVICE
    src_irq = 3'b100;
    req_q.push_back(2);
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_rd("rs_stat_svc", A_STAT, 32'hA);
    reset = 1'b1;
    tick();
    expect_st("rs_req", 32'h0);
    expect_rd("rs_stat", A_STAT, 32'h0);
    expect_rd("rs_mask", A_MASK, 32'h0);
    expect_rd("rs_pend", A_PEND, 32'h0);
    reset   = 1'b0;
    src_irq = 3'b000;
    tick();

    // W1C against a simultaneous new Timer0 edge, then a plain W1C
    src_irq = 3'b001;
    tick();
    src_irq = 3'b000;
    tick();
    src_irq = 3'b001;
    wr(A_PEND, 32'h1, 4'h1);
    expect_rd("w1c_vs_edge", A_PEND, 32'h1);
    wr(A_PEND, 32'h1, 4'h1);
    expect_rd("w1c_plain", A_PEND, EDGE ? 32'h0 : 32'h1);
    src_irq = 3'b000;
    tick();

    // Writes outside the window or without lane 0 are ignored
    wr(32'h0000_7f34, 32'h7, 4'h1);
    wr(32'h0001_7f24, 32'h7, 4'h1);
    wr(A_MASK, 32'h7, 4'he);
    expect_rd("win_mask", A_MASK, 32'h0);
    wr(A_MASK, 32'h5, 4'h1);
    expect_rd("mask_rw", A_MASK, 32'h5);
    expect_rd("eoi_read", A_EOI, 32'h0);
    tick();
    tick();

    n_chk++;
    if (req_q.size() != 0) begin
      n_fail++;
      $display("FAIL req_left: got %0d outstanding requests expected 0", req_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 addr  input  32  device address from bridge; register select = addr[3:2]; window 0x7f20-0x7f2f.
REQ-004 wdata  input  32  write data; only wdata[2:0] used.
REQ-005 we  input  4  byte write enables from bridge; a write takes effect only when we[0]=1.
REQ-006 rdata  output  32  combinational read data for addr[3:2]; unused bits 0.
REQ-007 src_irq  input  3  bit0 Timer0, bit1 Timer1, bit2 external interrupt.
REQ-008 int_req  output  1  registered interrupt request to CPU.
REQ-009 int_id  output  2  registered id of requested/in-service source (0,1,2).
REQ-010 int_ack  input  1  one-cycle CPU acknowledge of int_req.

Function
REQ-011 Registers: offset 0 PEND (R, W1C bits [2:0]); 1 MASK (RW [2:0], 1=enabled); 2 STAT (R: [1:0]=state, [3:2]=int_id); 3 EOI (W only, any value; reads 0).
REQ-012 Edge mode: pending[i] sets on cycle after src_irq[i] samples 0->1 (src_prev registered).
REQ-013 Pending set has priority over W1C clear and over ack clear of the same bit in the same cycle.
REQ-014 FSM states: IDLE=0, REQ=1, SERVICE=2; value 3 unreachable, decodes as IDLE.
REQ-015 IDLE: if (pending & mask)!=0, next state REQ, int_id latched to lowest set index (Timer0 > Timer1 > external).
REQ-016 REQ: int_req=1; int_id frozen; a newly pending higher-priority source does not change int_id.
REQ-017 REQ with int_ack=1: pending[int_id] cleared, next state SERVICE, int_req=0 from next cycle.
REQ-018 REQ with pending[int_id]&mask[int_id]=0 and no ack (masked or W1C-cleared): return to IDLE, int_req=0 next cycle; ack takes precedence when both occur.
REQ-019 SERVICE: int_req=0, int_id holds; pending keeps capturing; EOI write returns to IDLE.
REQ-020 int_ack outside REQ and EOI outside SERVICE are ignored.
REQ-021 Latency: src edge sampled at edge N -> PEND visible after N -> int_req high after edge N+1 (2 cycles).
REQ-022 After EOI, a still-pending enabled source re-enters REQ one cycle after IDLE.
REQ-023 Writes with addr outside 0x7f20-0x7f2f are ignored (bridge gating plus local check of addr[31:4]==0x7f2).

Reset
REQ-024 reset=1: pending=0, mask=0, src_prev=0, state=IDLE, int_req=0, int_id=0; rdata reflects these.
REQ-025 Reset in REQ or SERVICE aborts to IDLE with no request; a source held high across reset release counts as an edge.

Configuration
REQ-026 Macro INT_CTRL_EDGE_EN defined: edge mode per REQ-012/013.
REQ-027 Macro INT_CTRL_EDGE_EN undefined: level mode; pending[i] = registered src_irq[i]; W1C and ack clears have no lasting effect while source is high; src_prev not implemented.

Verification
REQ-028 MASK=3'b001, Timer0 rises at cycle 10 -> PEND=001 at 11, int_req=1, int_id=0 at 12.
REQ-029 Timer1 and external rise same cycle, MASK=111 -> int_id=1; after ack+EOI, int_id=2 request follows.
REQ-030 In REQ, write MASK=000 -> int_req=0 next cycle, state IDLE, PEND unchanged.
REQ-031 W1C PEND bit0 same cycle as new Timer0 edge -> PEND bit0 remains 1.
REQ-032 reset asserted in SERVICE -> next cycle STAT=0, int_req=0, MASK=0, PEND=0.
REQ-033 Without INT_CTRL_EDGE_EN, ext held high, ack+EOI -> re-request int_id=2 within 2 cycles.
